// File: rtl/uart_receiver_if.sv
// Byte handshake between the UART receiver FIFO head and its consumer.
// The receiver owns out/valid; the consumer owns ready.
interface uart_receiver_if;
   logic [7:0] out;
   logic       valid;
   logic       ready;

   modport master (output out, output valid, input ready);
   modport slave  (input out, input valid, output ready);
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, small FIFO.
// Bit timing uses the same COUNT_MAX (period minus one) convention as the transmitter.
module uart_receiver #(
   parameter int                     COUNT_WIDTH = 11,
   parameter logic [COUNT_WIDTH-1:0] COUNT_MAX   = 11'd1076,
   parameter int                     FIFO_LOG    = 2
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            in,
   uart_receiver_if.master bus,
   output logic            framing_error,
   output logic            overrun
);

   localparam int                     DEPTH     = 1 << FIFO_LOG;
   localparam logic [COUNT_WIDTH-1:0] HALF      = COUNT_MAX >> 1;
   localparam logic [FIFO_LOG:0]      FULL_OCC  = {1'b1, {FIFO_LOG{1'b0}}};

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, FERR} state_t;

   state_t                 state, state_nxt;
   logic                   rx_m, rx_s;
   logic [COUNT_WIDTH-1:0] cnt;
   logic [2:0]             bit_idx;
   logic [7:0]             shift;
   logic                   bit_end, push, ferr_set;

   logic [DEPTH-1:0][7:0]  mem;
   logic [FIFO_LOG-1:0]    wr_ptr, rd_ptr;
   logic [FIFO_LOG:0]      occ;
   logic                   pop, full, wr;

   // in is asynchronous; only rx_s feeds any decision
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= in;
         rx_s <= rx_m;
      end
   end

   always_comb begin
      state_nxt = state;
      bit_end   = 1'b0;
      push      = 1'b0;
      ferr_set  = 1'b0;
      case (state)
         IDLE:  if (!rx_s) state_nxt = START;
         START: if (cnt == HALF) state_nxt = rx_s ? IDLE : DATA;
         DATA: begin
            if (cnt == COUNT_MAX) begin
               bit_end = 1'b1;
               if (bit_idx == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            if (cnt == COUNT_MAX) begin
               if (rx_s) begin
                  push      = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ferr_set  = 1'b1;
                  state_nxt = FERR;
               end
            end
         end
         FERR:  if (rx_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // counter restarts on every state change and at each data bit boundary
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shift         <= '0;
         framing_error <= 1'b0;
      end else begin
         state         <= state_nxt;
         framing_error <= ferr_set;
         if (state_nxt != state || state == IDLE || bit_end)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         if (state != DATA)
            bit_idx <= '0;
         else if (bit_end)
            bit_idx <= bit_idx + 1'b1;
         if (bit_end)
            shift[bit_idx] <= rx_s;
      end
   end

   assign pop  = bus.valid && bus.ready;
   assign full = (occ == FULL_OCC);
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign wr   = push && (!full || pop);

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         mem     <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         occ     <= '0;
         overrun <= 1'b0;
      end else begin
         if (wr) begin
            mem[wr_ptr] <= shift;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !wr)
            overrun <= 1'b1;
         case ({wr, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   assign bus.out   = mem[rd_ptr];
   assign bus.valid = (occ != '0);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 cycles per bit and a 4-entry FIFO.
module tb_uart_receiver;
   logic CLK = 1'b0;
   logic RST_N;
   logic in;
   logic framing_error, overrun;

   uart_receiver_if bus ();

   uart_receiver #(
      .COUNT_WIDTH(11),
      .COUNT_MAX  (11'd15),
      .FIFO_LOG   (2)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .in           (in),
      .bus          (bus),
      .framing_error(framing_error),
      .overrun      (overrun)
   );

   always #5 CLK = ~CLK;

   int        vecs  = 0;
   int        miscs = 0;
   logic [7:0] q[$];
   int        vcyc  = 0;
   int        ferrs = 0;

   // popped bytes, valid-high cycles and framing pulses, observed mid-cycle
   always @(negedge CLK) begin
      if (RST_N) begin
         if (bus.valid && bus.ready) q.push_back(bus.out);
         if (bus.valid) vcyc++;
         if (framing_error) ferrs++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic idle(input int n);
      in = 1'b1;
      tick(n);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      in = 1'b0;
      tick(16);
      for (int i = 0; i < 8; i++) begin
         in = b[i];
         tick(16);
      end
      in = stop;
      tick(16);
   endtask

   task automatic clear_obs();
      q.delete();
      vcyc  = 0;
      ferrs = 0;
   endtask

   initial begin
      RST_N     = 1'b0;
      in        = 1'b1;
      bus.ready = 1'b0;
      tick(3);
      check("rst_valid", bus.valid, 0);
      check("rst_out", bus.out, 0);
      check("rst_ferr", framing_error, 0);
      check("rst_overrun", overrun, 0);
      RST_N     = 1'b1;
      bus.ready = 1'b1;
      idle(10);

      // 1: single byte
      clear_obs();
      send_frame(8'hA5, 1'b1);
      idle(20);
      check("t1_count", q.size(), 1);
      check("t1_byte", (q.size() > 0) ? q[0] : 8'hxx, 8'hA5);
      check("t1_valid_cycles", vcyc, 1);
      check("t1_ferr", ferrs, 0);
      check("t1_overrun", overrun, 0);

      // 2: short low glitch, then a real frame
      clear_obs();
      in = 1'b0;
      tick(4);
      idle(30);
      check("t2_glitch_count", q.size(), 0);
      check("t2_glitch_valid", vcyc, 0);
      check("t2_glitch_ferr", ferrs, 0);
      send_frame(8'h3C, 1'b1);
      idle(20);
      check("t2_count", q.size(), 1);
      check("t2_byte", (q.size() > 0) ? q[0] : 8'hxx, 8'h3C);

      // 3: bad stop bit followed by a held-low line
      clear_obs();
      send_frame(8'h3C, 1'b0);
      in = 1'b0;
      tick(40);
      check("t3_ferr_pulse", ferrs, 1);
      check("t3_no_byte", q.size(), 0);
      idle(20);
      check("t3_ferr_after_hold", ferrs, 1);
      send_frame(8'h81, 1'b1);
      idle(20);
      check("t3_count", q.size(), 1);
      check("t3_byte", (q.size() > 0) ? q[0] : 8'hxx, 8'h81);
      check("t3_ferr_final", ferrs, 1);

      // 4: overrun with a stalled consumer
      clear_obs();
      bus.ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1);
         idle(4);
      end
      idle(10);
      check("t4_overrun", overrun, 1);
      check("t4_valid", bus.valid, 1);
      check("t4_head", bus.out, 8'h01);
      bus.ready = 1'b1;
      tick(10);
      check("t4_drain_count", q.size(), 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("t4_drain%0d", i), (q.size() > i) ? q[i] : 8'hxx, 8'(i + 1));
      check("t4_empty", bus.valid, 0);
      check("t4_overrun_sticky", overrun, 1);

      // 5: back-to-back frames, no idle gap
      clear_obs();
      send_frame(8'hFF, 1'b1);
      send_frame(8'h00, 1'b1);
      idle(20);
      check("t5_count", q.size(), 2);
      check("t5_first", (q.size() > 0) ? q[0] : 8'hxx, 8'hFF);
      check("t5_second", (q.size() > 1) ? q[1] : 8'hxx, 8'h00);
      check("t5_ferr", ferrs, 0);

      // 6: reset during data bit 3 with one byte queued
      bus.ready = 1'b0;
      send_frame(8'h11, 1'b1);
      idle(10);
      check("t6_queued", bus.valid, 1);
      clear_obs();
      in = 1'b0;
      tick(16);
      for (int i = 0; i < 3; i++) begin
         in = 1'b0;
         tick(16);
      end
      in = 1'b1;
      tick(8);
      RST_N = 1'b0;
      tick(1);
      RST_N = 1'b1;
      check("t6_valid", bus.valid, 0);
      check("t6_out", bus.out, 0);
      check("t6_overrun", overrun, 0);
      tick(8);
      tick(64);
      tick(16);
      idle(10);
      bus.ready = 1'b1;
      idle(10);
      check("t6_no_partial", q.size(), 0);
      send_frame(8'h5A, 1'b1);
      idle(20);
      check("t6_count", q.size(), 1);
      check("t6_byte", (q.size() > 0) ? q[0] : 8'hxx, 8'h5A);
      check("t6_ferr", ferrs, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscs);
      $finish;
   end
endmodule
